// File: rtl/melody_player.sv
// Song ROM sequencer: fetches note/duration, holds each for dur*unit cycles and drives a square tone.
// Optional articulation gap between notes when MELODY_ARTIC_EN is defined.
//   state | meaning
//   IDLE  | waiting for start, outputs quiet
//   FETCH | latch ROM word and tempo, clear counters
//   PLAY  | tone (or rest) for dur_r units
//   GAP   | silent articulation gap (MELODY_ARTIC_EN only)
module melody_player #(
  parameter int NOTE_W   = 20,
  parameter int DUR_W    = 5,
  parameter int ADDR_W   = 10,
  parameter int SONG_LEN = 49,
  parameter int TICK_DIV = 12_500_000,
  parameter int GAP_CYC  = 500_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [1:0]        tempo_sel,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [DUR_W-1:0]  dur_in,
  output logic [ADDR_W-1:0] addr,
  output logic              tone,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
`ifdef MELODY_ARTIC_EN
  localparam logic [1:0] S_GAP   = 2'd3;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
`endif
  localparam int UNIT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

  logic [1:0]        state;
  logic [NOTE_W-1:0] note_r;
  logic [DUR_W-1:0]  dur_r;
  logic [UNIT_W-1:0] unit_last;
  logic [UNIT_W-1:0] unit_cnt;
  logic [DUR_W-1:0]  dur_cnt;
  logic [NOTE_W-1:0] half_cnt;
  logic              play_end;
  logic              entry_end;

  assign play_end = (state == S_PLAY) && (unit_cnt == unit_last) &&
                    (dur_cnt == dur_r - DUR_W'(1));

`ifdef MELODY_ARTIC_EN
  logic [GAP_W-1:0] gap_cnt;
  assign entry_end = (state == S_GAP) && (gap_cnt == GAP_LAST);
`else
  logic unused_gap;
  assign unused_gap = |GAP_CYC;
  assign entry_end  = play_end;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      tone      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      note_r    <= '0;
      dur_r     <= '0;
      unit_last <= '0;
      unit_cnt  <= '0;
      dur_cnt   <= '0;
      half_cnt  <= '0;
`ifdef MELODY_ARTIC_EN
      gap_cnt   <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= S_IDLE;
        addr  <= '0;
        tone  <= 1'b0;
        busy  <= 1'b0;
      end else if (entry_end) begin
        tone <= 1'b0;
        if (addr != LAST_ADDR) begin
          addr  <= addr + ADDR_W'(1);
          state <= S_FETCH;
        end else if (loop_en) begin
          addr  <= '0;
          state <= S_FETCH;
        end else begin
          addr  <= '0;
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state <= S_FETCH;
              addr  <= '0;
              busy  <= 1'b1;
            end
          end
          S_FETCH: begin
            note_r    <= note_in;
            dur_r     <= (dur_in == '0) ? DUR_W'(1) : dur_in;
            unit_last <= UNIT_W'((TICK_DIV >> tempo_sel) - 1);
            unit_cnt  <= '0;
            dur_cnt   <= '0;
            half_cnt  <= '0;
            tone      <= 1'b0;
            state     <= S_PLAY;
          end
          S_PLAY: begin
`ifdef MELODY_ARTIC_EN
            if (play_end) begin
              state   <= S_GAP;
              gap_cnt <= '0;
              tone    <= 1'b0;
            end else
`endif
            begin
              if (unit_cnt == unit_last) begin
                unit_cnt <= '0;
                dur_cnt  <= dur_cnt + DUR_W'(1);
              end else begin
                unit_cnt <= unit_cnt + UNIT_W'(1);
              end
              // note values 0 and 1 are rests
              if (note_r > NOTE_W'(1)) begin
                if (half_cnt == note_r - NOTE_W'(1)) begin
                  half_cnt <= '0;
                  tone     <= ~tone;
                end else begin
                  half_cnt <= half_cnt + NOTE_W'(1);
                end
              end else begin
                tone <= 1'b0;
              end
            end
          end
`ifdef MELODY_ARTIC_EN
          S_GAP: gap_cnt <= gap_cnt + GAP_W'(1);
`endif
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/melody_player.md
# melody_player

Parametrised tune sequencer for the alarm-clock audio path. It steps a combinational song ROM (address in, note half-period and duration out), holds each note for its duration at a selectable tempo, and drives a square-wave tone to the speaker output. It supports rests, one-shot or looped playback, and start/stop control from the alarm FSM.

## Interface
- `NOTE_W`, default 20: width of the note half-period word, in clock cycles.
- `DUR_W`, default 5: width of the duration word, in duration units.
- `ADDR_W`, default 10: song ROM address width.
- `SONG_LEN`, default 49: number of entries played; must satisfy 1 ≤ SONG_LEN ≤ 2^ADDR_W.
- `TICK_DIV`, default 12_500_000: clocks per duration unit at tempo_sel=0; must be a multiple of 8.
- `GAP_CYC`, default 500_000: articulation gap length in clocks; only used with `MELODY_ARTIC_EN`.

Ports:
- `clk` input 1: system clock. One clock domain; reset is asynchronous and active-low.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: level/pulse; begins playback from entry 0 when idle.
- `stop` input 1: aborts playback; has priority over start.
- `loop_en` input 1: when 1, wraps to entry 0 after the last entry instead of finishing.
- `tempo_sel` input 2: the unit length is TICK_DIV >> tempo_sel clocks.
- `note_in` input NOTE_W: ROM note for `addr`. A value ≤ 1 is a rest.
- `dur_in` input DUR_W: ROM duration for `addr`. A value of 0 is treated as 1.
- `addr` output ADDR_W: ROM address, registered.
- `tone` output 1: square-wave audio output, registered.
- `busy` output 1: high in FETCH, PLAY and GAP.
- `done` output 1: one-cycle pulse when a non-looped song completes.

## Operation
- States: IDLE, FETCH, PLAY, GAP. GAP exists only with the macro defined.
- **Reset:** state=IDLE, addr=0, tone=0, busy=0, done=0, and all counters cleared.
- **IDLE:**
  - start=1 and stop=0 → FETCH, with addr=0.
- **FETCH (1 cycle):**
  - Latch note_r=note_in, dur_r=max(dur_in,1) and unit_len=TICK_DIV>>tempo_sel.
  - Clear the unit, duration and half-period counters; tone=0.
  - Next state is PLAY.
- **PLAY:**
  - Unit counter counts 0..unit_len-1. At wrap, the duration counter increments.
  - PLAY lasts exactly dur_r*unit_len cycles.
  - If note_r ≤ 1 (rest), tone is held at 0.
  - Otherwise the half-period counter counts 0..note_r-1, and tone toggles at each wrap. The first toggle occurs on the note_r-th PLAY cycle.
- **End of the last PLAY cycle (macro off) or last GAP cycle (macro on):**
  - addr < SONG_LEN-1 → addr+1, FETCH.
  - addr = SONG_LEN-1 and loop_en=1 → addr=0, FETCH.
  - addr = SONG_LEN-1 and loop_en=0 → IDLE, addr=0, done=1 for one cycle.
  - loop_en is sampled only at this point.
- **stop=1 in any state:** next cycle state=IDLE, addr=0, tone=0, no done pulse.
- **start while busy:** ignored.
- **start and stop in the same cycle:** stop wins.
- tempo_sel changes take effect at the next FETCH only.
- **Arithmetic rules:**
  - Counters are sized to hold TICK_DIV-1, 2^DUR_W-1 and 2^NOTE_W-1 respectively.
  - No overflow is possible under the parameter constraints.
  - The addr increment never exceeds SONG_LEN-1.

## Timing
- Start to first tone activity:
  - start sampled → FETCH on the next cycle.
  - PLAY follows FETCH.
  - First tone rise occurs note_r cycles after PLAY entry.
- Per-entry period: 1 + dur_r*unit_len cycles. With the macro defined, add GAP_CYC.
- All outputs are registered. addr changes one cycle before the FETCH that uses it, so the ROM has one full cycle of combinational settle time.
- done rises on the cycle the state enters IDLE; busy falls on the same cycle.
- Reset asserted mid-note forces all outputs to their reset values immediately (asynchronous).

## Configuration
- `MELODY_ARTIC_EN` defined:
  - After each PLAY, the block enters GAP for GAP_CYC cycles with tone=0 and busy=1.
  - stop still aborts from GAP.
  - This separates repeated notes audibly.
- `MELODY_ARTIC_EN` undefined:
  - The GAP state and its counter are absent.
  - PLAY goes directly to the next FETCH.
  - The GAP_CYC parameter is unused.

## Test plan
Bench parameters: TICK_DIV=8, SONG_LEN=3; the bench ROM is note={4,1,2} and dur={2,0,1}.
- **Reset with inputs toggling:** addr=0, tone=0, busy=0 and done=0 throughout reset; no activity after release without start.
- **One-shot playback, macro off, tempo_sel=0, loop_en=0, start pulse:**
  - Entry 0: PLAY of 16 cycles, tone toggles every 4 cycles (4 toggles).
  - Entry 1: rest; dur 0 is treated as 1, so 8 cycles with tone=0.
  - Entry 2: 8 cycles, tone toggles every 2 cycles.
  - done pulses once, 35 cycles after the first FETCH.
- **Looped playback with tempo_sel=1, loop_en=1:**
  - Unit is 4 cycles; entry 0 PLAY lasts 8 cycles.
  - After entry 2, addr wraps to 0 with no done pulse.
  - Clearing loop_en during entry 1 ends the song after entry 2.
- **stop mid-PLAY of entry 0, asserted together with start:** next cycle state=IDLE, tone=0, addr=0, busy=0, no done pulse; a start during PLAY causes no restart.
- **Macro defined, GAP_CYC=3:** each entry period grows by 3 cycles with tone=0; total one-shot length is 44 cycles; stop during GAP aborts.
- **Asynchronous reset asserted mid-PLAY, between clock edges:** outputs clear immediately; playback resumes only on a new start after release.
